uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- UART transmitter that serialises a 32-bit Data_In word as BYTES_PER_WORD consecutive 8N1/8E1/8O1/8x2 frames, least-significant byte first.
- Produces the serial line Tx_dataOut and the bit-rate strobe Baud_Clk that feed the UART receiver path.
- Word-level valid/ready handshake on the host side.
- One clock domain; the baud divider is internal.

Parameters:
- CLKS_PER_BIT, 5208: Clock_In cycles per serial bit (50 MHz / 9600 baud); legal range ≥2.
- PARITY_EN, 1: 1 inserts a parity bit after the data bits; 0 omits it.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits per frame, 1 or 2.
- BYTES_PER_WORD, 4: frames sent per accepted word (1..4); upper bytes beyond this are not sent.

Ports:
- Clock_In  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Data_In  input  32  word to transmit; sampled only on acceptance.
- Tx_Start  input  1  word valid request.
- Tx_Ready  output  1  high only in IDLE; a word is accepted on a rising edge where Tx_Start=1 and Tx_Ready=1.
- Tx_Busy  output  1  high from the acceptance edge until the final stop bit completes.
- Tx_Done  output  1  one-cycle pulse in the last clock of the final stop bit of the word.
- Tx_dataOut  output  1  serial line; idle level 1.
- Baud_Clk  output  1  one-cycle pulse in the last clock of every transmitted bit period; 0 in IDLE.
- Byte_Index  output  2  index of the byte currently on the line; 0 in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State=IDLE, Tx_dataOut=1, Tx_Ready=1, Tx_Busy=0, Tx_Done=0, Baud_Clk=0, Byte_Index=0.
  - Baud counter, bit counter and shift register are cleared.
  - Reset mid-frame drops the line to 1 immediately and discards the word; no Tx_Done is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on acceptance:
  - Data_In is latched into the word register.
  - Baud counter is cleared to 0.
  - From the next cycle: Tx_dataOut=0, Tx_Ready=0, Tx_Busy=1.
- Bit timing:
  - Baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - Baud_Clk=1 when the counter equals CLKS_PER_BIT-1; every state transition out of START/DATA/PARITY/STOP happens on that cycle.
  - Each bit is held exactly CLKS_PER_BIT cycles; there is no jitter and no gap between frames.
- START -> DATA: 8 bits, LSB first, taken from byte Byte_Index of the latched word.
- DATA -> PARITY after bit 7 when PARITY_EN=1; otherwise DATA -> STOP.
  - Parity bit = XOR of the 8 data bits, inverted when PARITY_ODD=1.
- STOP: Tx_dataOut=1 for STOP_BITS bit periods.
  - At the end of STOP, if Byte_Index < BYTES_PER_WORD-1: increment Byte_Index and go to START (back-to-back frames).
  - Otherwise: pulse Tx_Done, go to IDLE, Byte_Index=0.
- Tx_Ready rises the cycle after Tx_Done, so consecutive words always have ≥1 idle clock between them.
- Tx_Start while Busy is ignored: no queueing, and the latched word is not altered.
- Data_In changing after acceptance has no effect.
- Frame length = 1+8+PARITY_EN+STOP_BITS bits.
- Word duration = BYTES_PER_WORD × frame length × CLKS_PER_BIT cycles, measured from the acceptance edge to the edge after Tx_Done.

Test Plan:
All scenarios use CLKS_PER_BIT=16 with other parameters at default unless stated.

1. Reset=0 then released, no Tx_Start -> Tx_dataOut=1, Tx_Ready=1, Baud_Clk never pulses for 1000 cycles.

2. Data_In=32'd8900 (0x000022C4), Tx_Start one cycle, even parity -> expected line waveform, each bit exactly 16 clocks:
   - Frame 0 (byte C4): 0 | 0,0,1,0,0,0,1,1 | parity 1 | stop 1
   - Frame 1 (byte 22): 0 | 0,1,0,0,0,1,0,0 | parity 0 | stop 1
   - Frames 2 and 3 (byte 00): 0 | eight 0s | parity 0 | stop 1
   - Tx_Done pulses 704 cycles after acceptance; 44 Baud_Clk pulses total.

3. PARITY_ODD=1, Data_In=32'd8901 (byte0=C5, four ones) -> byte0 parity bit=1; byte1 (22) parity=1; bytes 2-3 parity=1.

4. STOP_BITS=2, PARITY_EN=0, Data_In=32'hA55A0FF0 -> 11-bit frames with two 1 stop bits; Tx_Done at 4×11×16=704 cycles; byte order F0,0F,5A,A5.

5. Tx_Start held high continuously with Data_In changing every cycle -> each word equals Data_In at its acceptance edge; exactly one idle cycle (Tx_Ready=1, line=1) between words.

6. Reset asserted during frame 1 DATA bit 3 -> Tx_dataOut=1 in the same cycle, no Tx_Done; after release, Tx_Ready=1 and a new word 8902 transmits correctly from byte 0.

Source files
------------

// File: rtl/uart_word_tx.sv
// Word-level UART transmitter: sends BYTES_PER_WORD back-to-back serial frames,
// least-significant byte first, with optional parity and one or two stop bits.
module uart_word_tx #(
  parameter int CLKS_PER_BIT   = 5208,
  parameter int PARITY_EN      = 1,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        Clock_In,
  input  logic        Reset,
  input  logic [31:0] Data_In,
  input  logic        Tx_Start,
  output logic        Tx_Ready,
  output logic        Tx_Busy,
  output logic        Tx_Done,
  output logic        Tx_dataOut,
  output logic        Baud_Clk,
  output logic [1:0]  Byte_Index
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [1:0]      LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_idx;
  logic [31:0]      word_q;
  logic [7:0]       shift_q;
  logic [7:0]       cur_byte;
  logic             baud_tick;
  logic             accept;
  logic             parity_bit;

  assign baud_tick  = (state_q != IDLE) && (baud_cnt == CNT_MAX);
  assign accept     = (state_q == IDLE) && Tx_Start;
  assign cur_byte   = word_q[{byte_idx, 3'b000} +: 8];
  assign parity_bit = (^cur_byte) ^ (PARITY_ODD != 0);

  assign Tx_Ready   = (state_q == IDLE);
  assign Tx_Busy    = (state_q != IDLE);
  assign Baud_Clk   = baud_tick;
  assign Byte_Index = byte_idx;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    Tx_dataOut = 1'b1;
    Tx_Done    = 1'b0;
    case (state_q)
      IDLE:   if (Tx_Start) state_d = START;
      START: begin
        Tx_dataOut = 1'b0;
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        Tx_dataOut = shift_q[0];
        if (baud_tick && bit_cnt == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        Tx_dataOut = parity_bit;
        if (baud_tick) state_d = STOP;
      end
      STOP: begin
        if (baud_tick && bit_cnt == LAST_STOP) begin
          if (byte_idx == LAST_BYTE) begin
            state_d = IDLE;
            Tx_Done = 1'b1;
          end else begin
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // bit_cnt wraps 7 -> 0 leaving DATA, so it is already cleared for counting stop bits
  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      shift_q  <= '0;
    end else begin
      if (state_q == IDLE || baud_tick) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + CNT_W'(1);

      if (accept) begin
        word_q   <= Data_In;
        byte_idx <= '0;
        bit_cnt  <= '0;
      end

      if (baud_tick) begin
        case (state_q)
          START: begin
            shift_q <= cur_byte;
            bit_cnt <= '0;
          end
          DATA: begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          STOP: begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt  <= '0;
              byte_idx <= (byte_idx == LAST_BYTE) ? 2'd0 : byte_idx + 2'd1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three parameter variants share stimulus and are checked
// every cycle against a frame-list model, plus literal timing/waveform expectations.
module tb_uart_word_tx;

  localparam int CPB  = 16;
  localparam int FCYC = 11 * CPB;  // all three variants use 11-bit frames

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        tx_start;
  logic [2:0]  ready, busy, done, line, baud;
  logic [1:0]  idx [3];

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    chk_en  = 1'b0;
  int    pe_p [3] = '{1, 1, 0};
  int    po_p [3] = '{0, 1, 0};
  int    sb_p [3] = '{1, 1, 2};
  string nm   [3] = '{"outputs_even", "outputs_odd", "outputs_stop2"};

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .Clock_In(clk), .Reset(rst_n), .Data_In(data_in), .Tx_Start(tx_start),
    .Tx_Ready(ready[0]), .Tx_Busy(busy[0]), .Tx_Done(done[0]), .Tx_dataOut(line[0]),
    .Baud_Clk(baud[0]), .Byte_Index(idx[0]));

  uart_word_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_b (
    .Clock_In(clk), .Reset(rst_n), .Data_In(data_in), .Tx_Start(tx_start),
    .Tx_Ready(ready[1]), .Tx_Busy(busy[1]), .Tx_Done(done[1]), .Tx_dataOut(line[1]),
    .Baud_Clk(baud[1]), .Byte_Index(idx[1]));

  uart_word_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
    .Clock_In(clk), .Reset(rst_n), .Data_In(data_in), .Tx_Start(tx_start),
    .Tx_Ready(ready[2]), .Tx_Busy(busy[2]), .Tx_Done(done[2]), .Tx_dataOut(line[2]),
    .Baud_Clk(baud[2]), .Byte_Index(idx[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line bits of a whole word in transmission order, one entry per bit period.
  function automatic logic [63:0] frame_bits(input logic [31:0] w, input int pe, input int po,
                                             input int sb);
    logic [63:0] b = '1;
    logic [7:0]  by;
    int          n = 0;
    for (int f = 0; f < 4; f++) begin
      by = w[8*f +: 8];
      b[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin b[n] = by[i]; n++; end
      if (pe != 0) begin b[n] = (^by) ^ po[0]; n++; end
      for (int s = 0; s < sb; s++) begin b[n] = 1'b1; n++; end
    end
    return b;
  endfunction

  // Model: cycles elapsed since acceptance (-1 when idle) and the word's bit list.
  int          m_cyc  [3] = '{-1, -1, -1};
  logic [63:0] m_bits [3];

  function automatic int flen(input int k);
    return 9 + pe_p[k] + sb_p[k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) m_cyc[k] <= -1;
      else if (m_cyc[k] < 0) begin
        if (tx_start) begin
          m_bits[k] <= frame_bits(data_in, pe_p[k], po_p[k], sb_p[k]);
          m_cyc[k]  <= 0;
        end
      end else if (m_cyc[k] == 4 * flen(k) * CPB - 1) m_cyc[k] <= -1;
      else m_cyc[k] <= m_cyc[k] + 1;
    end
  end

  // Bundle {ready, busy, done, baud, line, idx} compared every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [6:0] exp, act;
        int         b;
        act = {ready[k], busy[k], done[k], baud[k], line[k], idx[k]};
        if (m_cyc[k] < 0) exp = 7'b1000_100;
        else begin
          b   = m_cyc[k] / CPB;
          exp = {1'b0, 1'b1, m_cyc[k] == 4 * flen(k) * CPB - 1, (m_cyc[k] % CPB) == CPB - 1,
                 m_bits[k][b], 2'(b / flen(k))};
        end
        check(nm[k], 32'(act), 32'(exp));
      end
    end
  end

  logic [7:0] samp_byte [3][4];
  logic       samp9     [3][4];
  logic       samp10    [3][4];

  // Sends one word and samples every line bit at mid-period. abort_k >= 0 asserts
  // reset in that cycle; spam injects an ignored Tx_Start while busy.
  task automatic run_word(input logic [31:0] w, input bit spam, input int abort_k,
                          output int done_k, output int baud_n);
    int f, r;
    @(posedge clk); #1;
    data_in  = w;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    data_in  = $urandom();
    done_k   = -1;
    baud_n   = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      baud_n += int'(baud[0]);
      f = k / FCYC;
      r = k % FCYC;
      if (f < 4 && r % CPB == CPB / 2) begin
        for (int d = 0; d < 3; d++) begin
          if (r / CPB >= 1 && r / CPB <= 8) samp_byte[d][f][r / CPB - 1] = line[d];
          if (r / CPB == 9)  samp9[d][f]  = line[d];
          if (r / CPB == 10) samp10[d][f] = line[d];
        end
      end
      if (spam && k == 300) begin tx_start = 1'b1; data_in = $urandom(); end
      if (spam && k == 301) tx_start = 1'b0;
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        #1 check("reset_line_high", 32'(line), 32'h7);
        check("reset_no_done", 32'(done), 32'h0);
        check("reset_ready", 32'(ready), 32'h7);
        return;
      end
      if (done[0]) begin done_k = k; break; end
    end
    check("done_timeout", 32'(done_k >= 0), 32'h1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ready == 3'b111) begin ok = 1'b1; break; end
    end
    check("idle_timeout", 32'(ok), 32'h1);
  endtask

  initial begin
    int dk, bn, cnt_baud, cnt_low, gap, words;
    bit after;
    logic [31:0] w;

    rst_n    = 1'b0;
    tx_start = 1'b0;
    data_in  = '0;

    // hand-computed frames pin the model: {stop(s)/parity, byte, start}
    w = frame_bits(32'd8900, 1, 0, 1);
    check("model_frame_even", 32'(w[10:0]), 32'h788);        // 1,1,C4,0
    w = frame_bits(32'd8901, 1, 1, 1);
    check("model_frame_odd", 32'(w[10:0]), 32'h78A);         // 1,1,C5,0
    w = frame_bits(32'hA55A0FF0, 0, 0, 2);
    check("model_frame_stop2", 32'(w[10:0]), 32'h7E0);       // 1,1,F0,0

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // idle after reset
    cnt_baud = 0;
    cnt_low  = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      cnt_baud += int'(baud != 3'b000);
      cnt_low  += int'(line != 3'b111);
    end
    check("idle_baud_pulses", 32'(cnt_baud), 32'd0);
    check("idle_line_low", 32'(cnt_low), 32'd0);

    // even parity waveform, timing and pulse count
    run_word(32'd8900, 1'b0, -1, dk, bn);
    check("done_latency", 32'(dk + 1), 32'd704);
    check("baud_pulses", 32'(bn), 32'd44);
    check("bytes_8900", {samp_byte[0][3], samp_byte[0][2], samp_byte[0][1], samp_byte[0][0]},
          32'h000022C4);
    check("parity_even", 32'({samp9[0][3], samp9[0][2], samp9[0][1], samp9[0][0]}), 32'h1);

    // odd parity
    run_word(32'd8901, 1'b0, -1, dk, bn);
    check("parity_odd", 32'({samp9[1][3], samp9[1][2], samp9[1][1], samp9[1][0]}), 32'hF);

    // two stop bits, no parity
    run_word(32'hA55A0FF0, 1'b0, -1, dk, bn);
    check("done_latency_stop2", 32'(dk + 1), 32'd704);
    check("bytes_stop2", {samp_byte[2][3], samp_byte[2][2], samp_byte[2][1], samp_byte[2][0]},
          32'hA55A0FF0);
    check("stop_bits", 32'({samp9[2][3], samp9[2][2], samp9[2][1], samp9[2][0],
                            samp10[2][3], samp10[2][2], samp10[2][1], samp10[2][0]}), 32'hFF);

    // Tx_Start held, Data_In changing every cycle
    @(posedge clk); #1;
    tx_start = 1'b1;
    data_in  = $urandom();
    gap   = 0;
    words = 0;
    after = 1'b0;
    for (int c = 0; c < 2300; c++) begin
      @(negedge clk);
      if (done[0]) after = 1'b1;
      else if (after) begin
        if (ready[0]) gap++;
        else begin
          check("handshake_gap", 32'(gap), 32'd1);
          gap   = 0;
          after = 1'b0;
          words++;
        end
      end
      @(posedge clk); #1 data_in = $urandom();
    end
    tx_start = 1'b0;
    check("streamed_words", 32'(words >= 3), 32'h1);
    wait_idle();

    // reset during frame 1, DATA bit 3
    run_word(32'd8900, 1'b0, FCYC + 4 * CPB + 5, dk, bn);
    repeat (3) @(negedge clk);
    check("reset_hold_no_done", 32'(done), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(ready), 32'h7);
    run_word(32'd8902, 1'b0, -1, dk, bn);
    check("done_after_reset", 32'(dk + 1), 32'd704);
    check("bytes_8902", {samp_byte[0][3], samp_byte[0][2], samp_byte[0][1], samp_byte[0][0]},
          32'h000022C6);

    // random words, random gaps, ignored Tx_Start while busy
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 12)) @(posedge clk);
      w = $urandom();
      run_word(w, 1'b1, -1, dk, bn);
      check("rand_latency", 32'(dk + 1), 32'd704);
      check("rand_bytes", {samp_byte[0][3], samp_byte[0][2], samp_byte[0][1], samp_byte[0][0]}, w);
    end
    wait_idle();

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
